rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

- Shares the single combinational `ROM_array` (8-bit ADDR in, 8-bit DATA_OUT out) between two requesters in the toy processor:
  - port A: instruction fetch;
  - port B: constant/data load.
- Serialises accesses, inserts a programmable number of settling cycles, and returns registered read data with a one-cycle ACK pulse per access.
- Sits between the fetch/load units and `ROM_array`; it is the only driver of the ROM address bus.

## Interface
- `ADDR_W`, default 8: address width; matches ROM ADDR.
- `DATA_W`, default 8: data width; matches ROM DATA_OUT.
- `WAIT_STATES`, default 1: extra settling cycles before ROM data is sampled. Legal range 0..15.
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `REQ_A`  in  1: port A request; held until `ACK_A`.
- `ADDR_A`  in  ADDR_W: port A address; stable while `REQ_A` is high.
- `ACK_A`  out  1: one-cycle pulse; `DATA_A` is valid in that cycle.
- `DATA_A`  out  DATA_W: last data read for port A; held until the next `ACK_A`.
- `REQ_B`, `ADDR_B`, `ACK_B`, `DATA_B`: identical semantics for port B.
- `ROM_ADDR`  out  ADDR_W: registered address to `ROM_array` ADDR.
- `ROM_DATA`  in  DATA_W: from `ROM_array` DATA_OUT.
- `BUSY`  out  1: high whenever the FSM is not in IDLE.

## Operation
**FSM states:** IDLE, ACCESS, DONE.

**IDLE**
- If no REQ is high: stay in IDLE; `ROM_ADDR` holds its last value.
- If exactly one REQ is high: grant that port.
- If both REQs are high: round-robin; grant the port not recorded in `LAST_GNT`.
- On a grant, at the same edge:
  - `ROM_ADDR` <= granted port's ADDR;
  - OWNER <= port;
  - `LAST_GNT` <= port;
  - CNT <= WAIT_STATES;
  - next state = ACCESS.

**ACCESS**
- If CNT != 0: CNT <= CNT-1 and stay in ACCESS.
- If CNT == 0: OWNER's DATA register <= `ROM_DATA`, OWNER's ACK <= 1, next state = DONE.

**DONE**
- ACK is high for exactly this cycle.
- Next state = IDLE unconditionally. REQ is not sampled in DONE.
- The requester must drop REQ, or present a new ADDR with REQ held high, at the edge that ends DONE.

**General rules**
- CNT is 4 bits, counts down only, and never wraps (it is loaded only in IDLE).
- The non-owner port's DATA and ACK never change during another port's access.
- A REQ that rises during ACCESS or DONE waits until IDLE. No request is lost, and there is no preemption.
- Reset mid-access (`RST_N` low in any state) immediately forces:
  - state = IDLE, ACK_A = ACK_B = 0;
  - `DATA_A` = `DATA_B` = 0, `ROM_ADDR` = 0;
  - CNT = 0, `LAST_GNT` = B.
  - The in-flight access is discarded, and the requester re-issues it after reset.

## Timing
- **Reset values:**
  - ACK_A = ACK_B = 0, `BUSY` = 0;
  - `DATA_A` = `DATA_B` = 0, `ROM_ADDR` = 0;
  - internally `LAST_GNT` = B, so port A wins the first tie.
- **Latency:** REQ high before grant edge e0 → ACK high in the cycle following edge e0+WAIT_STATES+1, i.e. WAIT_STATES+2 cycles. This is 3 cycles at default, 2 at WAIT_STATES=0.
- **`ROM_ADDR` stability:** `ROM_ADDR` is stable for WAIT_STATES+1 full cycles before `ROM_DATA` is sampled.
- **Throughput:** one access per WAIT_STATES+3 cycles (IDLE + ACCESS×(WAIT_STATES+1) + DONE). With both ports saturated, grants strictly alternate A, B, A, B.
- **`BUSY`:** combinational from state; it rises in the cycle after the grant edge.

## Configuration
- Macro: `ROM_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority; port A wins every tie. `LAST_GNT` is still updated but ignored.
- Undefined (default): round-robin as described in Operation.

## Test plan
The ROM model returns DATA = ADDR ^ 8'hA5. WAIT_STATES = 1 unless stated.

- **Reset:** assert `RST_N`=0 for 3 cycles, then release.
  - Expect all outputs 0.
  - Then REQ_A=1 with ADDR_A=8'h10 → ACK_A in the 3rd cycle, `DATA_A`=8'hB5, `ROM_ADDR`=8'h10.
- **Tie, round-robin:** REQ_A (ADDR 8'h01) and REQ_B (ADDR 8'h02) both held high for 4 accesses.
  - Expect ACK order A, B, A, B; `DATA_A`=8'hA4, `DATA_B`=8'hA7; an ACK every 4 cycles.
- **Fixed priority:** rerun the tie scenario with `ROM_ARB_FIXED_PRIO_EN` defined.
  - Expect only A to be acknowledged while REQ_A stays high.
  - After REQ_A drops, B is acknowledged once.
- **Late request:** REQ_B rises during an A ACCESS.
  - A completes unaffected.
  - B is granted in the IDLE cycle after DONE; `DATA_A` is unchanged.
- **Reset mid-access:** pull `RST_N` low during ACCESS with ADDR_A=8'hFF.
  - Expect no ACK_A, `DATA_A`=0, `BUSY`=0 immediately.
  - After release, the re-issued request returns 8'h5A.
- **WAIT_STATES=0 sweep:** port A alone sweeps ADDR 0..255.
  - Every ACK arrives 2 cycles after its REQ.
  - `DATA_A` = ADDR ^ 8'hA5 for all 256 addresses, including the 8'hFF→8'h00 wrap.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: request/ack bundle for the two ROM requesters plus
// the ROM address/data pair and the BUSY status.
`timescale 1ns/1ps
interface rom_port_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              REQ_A;
   logic [ADDR_W-1:0] ADDR_A;
   logic              ACK_A;
   logic [DATA_W-1:0] DATA_A;
   logic              REQ_B;
   logic [ADDR_W-1:0] ADDR_B;
   logic              ACK_B;
   logic [DATA_W-1:0] DATA_B;
   logic [ADDR_W-1:0] ROM_ADDR;
   logic [DATA_W-1:0] ROM_DATA;
   logic              BUSY;

   // requester side (fetch/load units)
   modport master (
      output REQ_A, ADDR_A, REQ_B, ADDR_B,
      input  ACK_A, DATA_A, ACK_B, DATA_B, BUSY
   );

   // arbiter side
   modport slave (
      input  REQ_A, ADDR_A, REQ_B, ADDR_B, ROM_DATA,
      output ACK_A, DATA_A, ACK_B, DATA_B, ROM_ADDR, BUSY
   );

   // ROM_array side
   modport rom (
      input  ROM_ADDR,
      output ROM_DATA
   );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational ROM between instruction fetch
// (port A) and constant/data load (port B). Each access holds ROM_ADDR for
// WAIT_STATES+1 cycles, registers the ROM data and pulses the owner's ACK.
// Build option: define ROM_ARB_FIXED_PRIO_EN for fixed A-over-B priority;
// default is round-robin on ties. WAIT_STATES legal range is 0..15.
`timescale 1ns/1ps
module rom_port_arbiter #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic CLK,
   input  logic RST_N,
   rom_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
   typedef enum logic {PORT_A, PORT_B} port_e;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   port_e             owner_q, owner_d;
   port_e             last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0] data_a_q, data_a_d;
   logic [DATA_W-1:0] data_b_q, data_b_d;
   logic              ack_a_q, ack_a_d;
   logic              ack_b_q, ack_b_d;
   logic              req_any;
   logic              grant_b;

   // choose the winner among pending requests
   always_comb begin
      req_any = bus.REQ_A | bus.REQ_B;
`ifdef ROM_ARB_FIXED_PRIO_EN
      grant_b = bus.REQ_B & ~bus.REQ_A;
`else
      grant_b = bus.REQ_B & (~bus.REQ_A | (last_gnt_q == PORT_A));
`endif
   end

   // next-state and datapath updates for IDLE -> ACCESS -> DONE
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      rom_addr_d = rom_addr_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      ack_a_d    = 1'b0;
      ack_b_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_any) begin
               state_d    = ACCESS;
               cnt_d      = CNT_INIT;
               owner_d    = grant_b ? PORT_B : PORT_A;
               last_gnt_d = grant_b ? PORT_B : PORT_A;
               rom_addr_d = grant_b ? bus.ADDR_B : bus.ADDR_A;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               if (owner_q == PORT_A) begin
                  data_a_d = bus.ROM_DATA;
                  ack_a_d  = 1'b1;
               end else begin
                  data_b_d = bus.ROM_DATA;
                  ack_b_d  = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset discards any in-flight access
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         owner_q    <= PORT_A;
         last_gnt_q <= PORT_B;
         rom_addr_q <= '0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         rom_addr_q <= rom_addr_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         ack_a_q    <= ack_a_d;
         ack_b_q    <= ack_b_d;
      end
   end

   assign bus.ROM_ADDR = rom_addr_q;
   assign bus.DATA_A   = data_a_q;
   assign bus.DATA_B   = data_b_q;
   assign bus.ACK_A    = ack_a_q;
   assign bus.ACK_B    = ack_b_q;
   assign bus.BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed stimulus with a scoreboard queue per DUT;
// monitors pop expectations whenever an ACK appears.
`timescale 1ns/1ps
module tb_rom_port_arbiter;

   typedef struct packed {
      logic       port;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];
   exp_t        exp0_q[$];
   logic [7:0]  mdl_a = 8'h00;
   logic [7:0]  mdl_b = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rom_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus  ();
   rom_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();

   rom_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut (
      .CLK(clk), .RST_N(rst_n), .bus(bus.slave));
   rom_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
      .CLK(clk), .RST_N(rst_n), .bus(bus0.slave));

   // ROM_array model
   assign bus.ROM_DATA  = bus.ROM_ADDR ^ 8'hA5;
   assign bus0.ROM_DATA = bus0.ROM_ADDR ^ 8'hA5;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic exp_t mk(input logic p, input logic [7:0] d);
      exp_t e;
      e.port = p;
      e.data = d;
      return e;
   endfunction

   // monitor for the WAIT_STATES=1 instance
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         mdl_a = 8'h00;
         mdl_b = 8'h00;
      end else if (bus.ACK_A || bus.ACK_B) begin
         check("ack_exclusive", {31'd0, bus.ACK_A & bus.ACK_B}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: ACK_A=%0b ACK_B=%0b with empty scoreboard", bus.ACK_A, bus.ACK_B);
         end else begin
            e = exp_q.pop_front();
            check("ack_port", {31'd0, bus.ACK_B}, {31'd0, e.port});
            if (e.port) begin
               check("data_b", {24'd0, bus.DATA_B}, {24'd0, e.data});
               check("data_a_held", {24'd0, bus.DATA_A}, {24'd0, mdl_a});
               mdl_b = e.data;
            end else begin
               check("data_a", {24'd0, bus.DATA_A}, {24'd0, e.data});
               check("data_b_held", {24'd0, bus.DATA_B}, {24'd0, mdl_b});
               mdl_a = e.data;
            end
         end
      end
   end

   // monitor for the WAIT_STATES=0 instance (port A only)
   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst_n && (bus0.ACK_A || bus0.ACK_B)) begin
         if (exp0_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack0: ACK_A=%0b ACK_B=%0b with empty scoreboard", bus0.ACK_A, bus0.ACK_B);
         end else begin
            e = exp0_q.pop_front();
            check("ws0_ack_port", {31'd0, bus0.ACK_B}, {31'd0, e.port});
            check("ws0_data_a", {24'd0, bus0.DATA_A}, {24'd0, e.data});
         end
      end
   end

   task automatic wait_ack(output int unsigned at);
      at = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.ACK_A || bus.ACK_B) begin
            at = cyc;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ACK within 40 cycles, expected one");
      at = cyc;
   endtask

   task automatic wait_ack0(output int unsigned at);
      at = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus0.ACK_A || bus0.ACK_B) begin
            at = cyc;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL ack0_timeout: no ACK within 40 cycles, expected one");
      at = cyc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      exp0_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned t0, at, at_prev;
      int unsigned tie_at[4];
      logic [7:0]  addr;

      bus.REQ_A = 1'b0; bus.ADDR_A = '0; bus.REQ_B = 1'b0; bus.ADDR_B = '0;
      bus0.REQ_A = 1'b0; bus0.ADDR_A = '0; bus0.REQ_B = 1'b0; bus0.ADDR_B = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_ack_a", {31'd0, bus.ACK_A}, 32'd0);
      check("rst_ack_b", {31'd0, bus.ACK_B}, 32'd0);
      check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
      check("rst_data_a", {24'd0, bus.DATA_A}, 32'd0);
      check("rst_data_b", {24'd0, bus.DATA_B}, 32'd0);
      check("rst_rom_addr", {24'd0, bus.ROM_ADDR}, 32'd0);
      rst_n = 1'b1;

      // first access after reset
      @(negedge clk);
      t0 = cyc;
      bus.ADDR_A = 8'h10;
      bus.REQ_A  = 1'b1;
      exp_q.push_back(mk(1'b0, 8'hB5));
      @(negedge clk);
      check("busy_after_grant", {31'd0, bus.BUSY}, 32'd1);
      wait_ack(at);
      check("first_latency", at - t0, 32'd3);
      check("first_rom_addr", {24'd0, bus.ROM_ADDR}, 32'h10);
      bus.REQ_A = 1'b0;

      // tie: both ports saturated
      do_reset();
      bus.ADDR_A = 8'h01;
      bus.ADDR_B = 8'h02;
      bus.REQ_A  = 1'b1;
      bus.REQ_B  = 1'b1;
`ifdef ROM_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b0, 8'hA4));
      exp_q.push_back(mk(1'b1, 8'hA7));
`else
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(mk(1'b0, 8'hA4));
         exp_q.push_back(mk(1'b1, 8'hA7));
      end
`endif
      for (int k = 0; k < 4; k++) begin
         wait_ack(tie_at[k]);
         if (k > 0) check("tie_interval", tie_at[k] - tie_at[k-1], 32'd4);
      end
`ifdef ROM_ARB_FIXED_PRIO_EN
      bus.REQ_A = 1'b0;
      wait_ack(at);
      check("fixed_b_interval", at - tie_at[3], 32'd4);
      bus.REQ_B = 1'b0;
`else
      bus.REQ_A = 1'b0;
      bus.REQ_B = 1'b0;
`endif

      // late request: B rises during A's ACCESS
      @(negedge clk);
      t0 = cyc;
      bus.ADDR_A = 8'h33;
      bus.REQ_A  = 1'b1;
      exp_q.push_back(mk(1'b0, 8'h96));
      @(negedge clk);
      bus.ADDR_B = 8'h44;
      bus.REQ_B  = 1'b1;
      exp_q.push_back(mk(1'b1, 8'hE1));
      wait_ack(at_prev);
      check("late_a_latency", at_prev - t0, 32'd3);
      bus.REQ_A = 1'b0;
      wait_ack(at);
      check("late_b_after_done", at - at_prev, 32'd4);
      bus.REQ_B = 1'b0;

      // reset in the middle of an access
      @(negedge clk);
      bus.ADDR_A = 8'hFF;
      bus.REQ_A  = 1'b1;
      @(negedge clk);
      check("mid_busy", {31'd0, bus.BUSY}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack_a", {31'd0, bus.ACK_A}, 32'd0);
      check("mid_rst_data_a", {24'd0, bus.DATA_A}, 32'd0);
      check("mid_rst_data_b", {24'd0, bus.DATA_B}, 32'd0);
      check("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
      check("mid_rst_rom_addr", {24'd0, bus.ROM_ADDR}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      exp_q.push_back(mk(1'b0, 8'h5A));
      wait_ack(at);
      check("reissue_latency", at - t0, 32'd3);
      bus.REQ_A = 1'b0;

      // WAIT_STATES=0 sweep, ending with the 8'hFF -> 8'h00 wrap
      for (int i = 0; i <= 256; i++) begin
         addr = 8'(i);
         @(negedge clk);
         t0 = cyc;
         bus0.ADDR_A = addr;
         bus0.REQ_A  = 1'b1;
         exp0_q.push_back(mk(1'b0, addr ^ 8'hA5));
         wait_ack0(at);
         check("ws0_latency", at - t0, 32'd2);
         bus0.REQ_A = 1'b0;
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      check("scoreboard0_drained", exp0_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
